// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the Z-stage ALU and its sequential Booth
// multiplier.
//   alu_op_t : 4-bit operation code (codes 12-15 are illegal)
//   state_t  : Z-stage control state
// ----------------------------------------------------------------------------
package alu_pkg;

   localparam int WIDTH     = 32;
   localparam int SHAMT_W   = 5;
   localparam int MUL_ITERS = 32;
   localparam int CNT_W     = 5;

   // Count value present during the final Booth iteration.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_ITERS - 1);

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_SHR  = 4'd4,
      OP_SHRA = 4'd5,
      OP_SHL  = 4'd6,
      OP_ROR  = 4'd7,
      OP_ROL  = 4'd8,
      OP_NEG  = 4'd9,
      OP_NOT  = 4'd10,
      OP_MUL  = 4'd11
   } alu_op_t;

   typedef enum logic {
      IDLE,
      MUL_ITER
   } state_t;

endpackage

// File: rtl/booth_mul_seq.sv
// ----------------------------------------------------------------------------
// booth_mul_seq : radix-2 Booth signed multiplier, one iteration per cycle.
//   clk          rising-edge clock
//   rst          synchronous active-high reset (aborts any multiply)
//   load         latch m/q and begin a 32-iteration multiply
//   m [31:0]     multiplicand (signed)
//   q [31:0]     multiplier (signed)
//   busy         high while iterating
//   last         high during the final iteration cycle
//   product[63:0] result of the iteration now in progress; the final
//                product when last is high
// ----------------------------------------------------------------------------
module booth_mul_seq
   import alu_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [WIDTH-1:0]     m,
   input  logic [WIDTH-1:0]     q,
   output logic                 busy,
   output logic                 last,
   output logic [2*WIDTH-1:0]   product
);

   // ACC is one bit wider than M so that subtracting M = -2^31 cannot overflow.
   logic [WIDTH:0]     acc_q, acc_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplr_q, mplr_d;
   logic               q1_q, q1_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               busy_q, busy_d;

   logic [WIDTH:0]     mcand_sx;
   logic [WIDTH:0]     acc_sum;
   logic [WIDTH:0]     acc_shift;
   logic [WIDTH-1:0]   mplr_shift;

   assign mcand_sx = {mcand_q[WIDTH-1], mcand_q};

   // Booth recode on {Q[0], q_1}, then arithmetic shift of {ACC, Q, q_1}.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no path leaves
      // it unassigned, which would otherwise infer a latch.
      acc_sum = acc_q;
      unique case ({mplr_q[0], q1_q})
         2'b01:   acc_sum = acc_q + mcand_sx;
         2'b10:   acc_sum = acc_q - mcand_sx;
         default: acc_sum = acc_q;
      endcase
      acc_shift  = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
      mplr_shift = {acc_sum[0], mplr_q[WIDTH-1:1]};
   end

   always_comb begin
      acc_d   = acc_q;
      mcand_d = mcand_q;
      mplr_d  = mplr_q;
      q1_d    = q1_q;
      count_d = count_q;
      busy_d  = busy_q;
      if (load) begin
         acc_d   = '0;
         mcand_d = m;
         mplr_d  = q;
         q1_d    = 1'b0;
         count_d = '0;
         busy_d  = 1'b1;
      end else if (busy_q) begin
         acc_d   = acc_shift;
         mplr_d  = mplr_shift;
         q1_d    = mplr_q[0];
         count_d = count_q + CNT_W'(1);
         busy_d  = (count_q != LAST_CNT);
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so all flops sample
      // their _d values from the same pre-edge snapshot.
      if (rst) begin
         acc_q   <= '0;
         mcand_q <= '0;
         mplr_q  <= '0;
         q1_q    <= 1'b0;
         count_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
         q1_q    <= q1_d;
         count_q <= count_d;
         busy_q  <= busy_d;
      end
   end

   assign busy    = busy_q;
   assign last    = busy_q && (count_q == LAST_CNT);
   assign product = {acc_shift[WIDTH-1:0], mplr_shift};

endmodule

// File: rtl/shl.sv
// ----------------------------------------------------------------------------
// shl : 32-bit left barrel shifter.
//   data_i  [31:0] value to shift
//   shamt_i [4:0]  shift amount
//   data_o  [31:0] data_i << shamt_i, zero filled
// ----------------------------------------------------------------------------
module shl
   import alu_pkg::*;
(
   input  logic [WIDTH-1:0]   data_i,
   input  logic [SHAMT_W-1:0] shamt_i,
   output logic [WIDTH-1:0]   data_o
);

   assign data_o = data_i << shamt_i;

endmodule

// File: rtl/shr.sv
// ----------------------------------------------------------------------------
// shr : 32-bit logical right barrel shifter.
//   data_i  [31:0] value to shift
//   shamt_i [4:0]  shift amount
//   data_o  [31:0] data_i >> shamt_i, zero filled
// ----------------------------------------------------------------------------
module shr
   import alu_pkg::*;
(
   input  logic [WIDTH-1:0]   data_i,
   input  logic [SHAMT_W-1:0] shamt_i,
   output logic [WIDTH-1:0]   data_o
);

   assign data_o = data_i >> shamt_i;

endmodule

// File: rtl/shra.sv
// ----------------------------------------------------------------------------
// shra : 32-bit arithmetic right barrel shifter.
//   data_i  [31:0] value to shift (two's complement)
//   shamt_i [4:0]  shift amount
//   data_o  [31:0] data_i >>> shamt_i, sign filled
// ----------------------------------------------------------------------------
module shra
   import alu_pkg::*;
(
   input  logic [WIDTH-1:0]   data_i,
   input  logic [SHAMT_W-1:0] shamt_i,
   output logic [WIDTH-1:0]   data_o
);

   assign data_o = WIDTH'($signed(data_i) >>> shamt_i);

endmodule

// File: rtl/alu_z_stage.sv
// ----------------------------------------------------------------------------
// alu_z_stage : ALU stage writing the 64-bit Z register (z_hi:z_lo).
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start       request strobe, accepted only while idle
//   op [3:0]    operation code (alu_op_t)
//   a  [31:0]   operand A (Y register; Booth multiplicand)
//   b  [31:0]   operand B (bus; multiplier / shift amount in b[4:0])
//   busy        high while a MUL is iterating
//   done        one-cycle pulse in the first cycle Z holds a new result
//   z_hi/z_lo   Z register
// Single-cycle ops complete on the accepting edge; MUL completes 32 edges
// after it is accepted.
// ----------------------------------------------------------------------------
module alu_z_stage
   import alu_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] z_hi,
   output logic [WIDTH-1:0] z_lo
);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   z_hi_q, z_hi_d;
   logic [WIDTH-1:0]   z_lo_q, z_lo_d;
   logic               done_q, done_d;

   alu_op_t            op_e;
   logic [SHAMT_W-1:0] shamt;
   logic [SHAMT_W:0]   shamt_inv;
   logic [WIDTH-1:0]   shr_res, shra_res, shl_res, ror_res, rol_res;
   logic [WIDTH-1:0]   alu_res;

   logic               mul_load, mul_busy, mul_last;
   logic [2*WIDTH-1:0] mul_product;

   assign op_e      = alu_op_t'(op);
   assign shamt     = b[SHAMT_W-1:0];
   assign shamt_inv = (SHAMT_W+1)'(WIDTH) - {1'b0, shamt};

   shr  u_shr  (.data_i(a), .shamt_i(shamt), .data_o(shr_res));
   shra u_shra (.data_i(a), .shamt_i(shamt), .data_o(shra_res));
   shl  u_shl  (.data_i(a), .shamt_i(shamt), .data_o(shl_res));

   // A shift by the full width yields zero, so amount 0 returns a unchanged.
   assign ror_res = (a >> shamt) | (a << shamt_inv);
   assign rol_res = (a << shamt) | (a >> shamt_inv);

   always_comb begin
      alu_res = '0;
      case (op_e)
         OP_ADD:  alu_res = a + b;
         OP_SUB:  alu_res = a - b;
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_SHR:  alu_res = shr_res;
         OP_SHRA: alu_res = shra_res;
         OP_SHL:  alu_res = shl_res;
         OP_ROR:  alu_res = ror_res;
         OP_ROL:  alu_res = rol_res;
         OP_NEG:  alu_res = '0 - a;
         OP_NOT:  alu_res = ~a;
         default: alu_res = '0;   // MUL handled by the FSM; 12-15 give zero
      endcase
   end

   booth_mul_seq u_mul (
      .clk     (clk),
      .rst     (rst),
      .load    (mul_load),
      .m       (a),
      .q       (b),
      .busy    (mul_busy),
      .last    (mul_last),
      .product (mul_product)
   );

   always_comb begin
      state_d  = state_q;
      z_hi_d   = z_hi_q;
      z_lo_d   = z_lo_q;
      done_d   = 1'b0;
      mul_load = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (op_e == OP_MUL) begin
                  mul_load = 1'b1;
                  state_d  = MUL_ITER;
               end else begin
                  z_hi_d = '0;
                  z_lo_d = alu_res;
                  done_d = 1'b1;
               end
            end
         end
         MUL_ITER: begin
            // start is ignored here; the request is simply dropped.
            if (mul_last) begin
               z_hi_d  = mul_product[2*WIDTH-1:WIDTH];
               z_lo_d  = mul_product[WIDTH-1:0];
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         z_hi_q  <= '0;
         z_lo_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         z_hi_q  <= z_hi_d;
         z_lo_q  <= z_lo_d;
         done_q  <= done_d;
      end
   end

   assign busy = mul_busy;
   assign done = done_q;
   assign z_hi = z_hi_q;
   assign z_lo = z_lo_q;

endmodule

// File: tb/tb_alu_z_stage.sv
// ----------------------------------------------------------------------------
// tb_alu_z_stage : self-checking bench for alu_z_stage. Expected results come
// from a behavioural model using plain arithmetic and bit-by-bit rotation.
// ----------------------------------------------------------------------------
module tb_alu_z_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  op;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] z_hi, z_lo;

   int          n_pass  = 0;
   int          n_total = 0;
   logic [63:0] exp_z   = 64'h0;

   alu_z_stage dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .z_hi  (z_hi),
      .z_lo  (z_lo)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // Reference model: result of one operation as the 64-bit Z value.
   function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] x,
                                         input logic [31:0] y);
      int          s;
      logic [31:0] r;
      longint      p;
      s = int'(y % 32);
      r = 32'h0;
      case (o)
         4'd0:  r = x + y;
         4'd1:  r = x - y;
         4'd2:  r = x & y;
         4'd3:  r = x | y;
         4'd4:  r = x >> s;
         4'd5:  begin r = x; for (int i = 0; i < s; i++) r = {r[31], r[31:1]}; end
         4'd6:  r = x << s;
         4'd7:  begin r = x; for (int i = 0; i < s; i++) r = {r[0], r[31:1]}; end
         4'd8:  begin r = x; for (int i = 0; i < s; i++) r = {r[30:0], r[31]}; end
         4'd9:  r = 32'h0 - x;
         4'd10: r = ~x;
         4'd11: begin
            p = longint'($signed(x)) * longint'($signed(y));
            return p;
         end
         default: r = 32'h0;
      endcase
      return {32'h0, r};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, expv);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one request for a single edge, then scramble the operands so any
   // late sampling of a/b/op would show up.
   task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      tick();
      start = 1'b0;
      op    = 4'($urandom_range(0, 15));
      a     = $urandom;
      b     = $urandom;
   endtask

   task automatic single(input string tag, input logic [3:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [63:0] expv);
      issue(o, x, y);
      exp_z = expv;
      check(tag, {z_hi, z_lo}, exp_z);
      check({tag, "_done"}, 64'(done), 64'd1);
   endtask

   task automatic run_mul(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] expv, input bit inject);
      logic [63:0] z_prev;
      int          busy_cnt;
      int          done_at;
      bit          held;
      z_prev   = exp_z;
      busy_cnt = 0;
      done_at  = -1;
      held     = 1'b1;
      issue(4'd11, x, y);
      for (int i = 0; i <= 40; i++) begin
         if (i > 0) begin
            tick();
            start = 1'b0;
         end
         if (busy) busy_cnt++;
         if (busy && ({z_hi, z_lo} !== z_prev)) held = 1'b0;
         if (done) begin
            done_at = i;
            break;
         end
         if (inject && i == 5) begin
            start = 1'b1;
            op    = 4'd0;
            a     = 32'd1;
            b     = 32'd1;
         end
      end
      start = 1'b0;
      exp_z = expv;
      check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
      check({tag, "_done_edge"}, 64'(done_at), 64'd32);
      check({tag, "_z_held"}, 64'(held), 64'd1);
      check({tag, "_product"}, {z_hi, z_lo}, exp_z);
      tick();
      check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
   endtask

   initial begin
      bit          saw_done;
      logic [3:0]  ro;
      logic [31:0] ra, rb;

      rst   = 1'b1;
      start = 1'b0;
      op    = 4'd0;
      a     = 32'h0;
      b     = 32'h0;
      tick();
      tick();
      rst = 1'b0;
      check("reset_z", {z_hi, z_lo}, 64'h0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);

      // Back-to-back single-cycle ops.
      single("add_5_7", 4'd0, 32'd5, 32'd7, 64'h0000_0000_0000_000C);
      single("sub_5_7", 4'd1, 32'd5, 32'd7, 64'h0000_0000_FFFF_FFFE);
      tick();
      check("idle_done_low", 64'(done), 64'd0);
      check("idle_z_hold", {z_hi, z_lo}, exp_z);

      single("shra_neg", 4'd5, 32'h8000_0000, 32'h0000_0024, 64'h0000_0000_F800_0000);
      single("rol_1", 4'd8, 32'h8000_0001, 32'd1, 64'h0000_0000_0000_0003);
      single("ror_0", 4'd7, 32'h1234_5678, 32'hFFFF_FFE0, 64'h0000_0000_1234_5678);

      // MUL with a start pulsed mid-iteration that must be dropped.
      run_mul("mul_m3_7", 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1);
      run_mul("mul_min_min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
      run_mul("mul_max_m1", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0001, 1'b0);

      // Randomized operations against the model.
      for (int k = 0; k < 24; k++) begin
         ro = 4'($urandom_range(0, 15));
         ra = $urandom;
         rb = $urandom;
         if (ro == 4'd11) run_mul($sformatf("rnd%0d_mul", k), ra, rb, model(ro, ra, rb), 1'b0);
         else             single($sformatf("rnd%0d_op%0d", k, ro), ro, ra, rb, model(ro, ra, rb));
      end

      // Reset during iteration 10 of a MUL aborts it.
      issue(4'd11, 32'd5, 32'd9);
      repeat (10) tick();
      rst = 1'b1;
      tick();
      rst   = 1'b0;
      exp_z = 64'h0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_z", {z_hi, z_lo}, exp_z);
      check("abort_done", 64'(done), 64'd0);
      saw_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done) saw_done = 1'b1;
      end
      check("abort_no_done", 64'(saw_done), 64'd0);
      single("add_after_abort", 4'd0, 32'd1, 32'd1, 64'h0000_0000_0000_0002);

      // Illegal op clears Z and still completes.
      single("illegal_14", 4'd14, 32'h0000_FFFF, 32'd1, 64'h0);
      tick();
      check("illegal_done_once", 64'(done), 64'd0);

      // Reset wins over start in the same cycle.
      single("add_3_4", 4'd0, 32'd3, 32'd4, 64'h0000_0000_0000_0007);
      rst   = 1'b1;
      start = 1'b1;
      op    = 4'd0;
      a     = 32'd3;
      b     = 32'd4;
      tick();
      rst   = 1'b0;
      start = 1'b0;
      exp_z = 64'h0;
      check("rst_start_z", {z_hi, z_lo}, exp_z);
      check("rst_start_done", 64'(done), 64'd0);
      rst   = 1'b1;
      start = 1'b1;
      op    = 4'd11;
      tick();
      rst   = 1'b0;
      start = 1'b0;
      check("rst_start_mul_busy", 64'(busy), 64'd0);
      tick();
      check("rst_start_mul_idle", 64'(busy), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
